mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller of the five-stage pipeline, placed directly upstream of the data memory. It accepts one memory operation per handshake from the EX/MEM boundary, owns the stack pointer, and generates the data-memory address, write data and strobes. Two-word operations (CALL/RET) are sequenced over two access cycles. Results go to the MEM/WB boundary as a registered 32-bit value.

## Interface
- `ADDR_W`, 32: address width driven to data memory.
- `SP_RESET`, 32'h0000_07FF: stack-pointer reset value, the top of the 2^11-word memory. The stack grows down.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid from EX.
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at a rising edge.
- `in_op`  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET; 7 is treated as NOP.
- `in_addr`  in  32  effective address for LOAD/STORE.
- `in_wdata`  in  32  store/push data (bits [15:0] used) or the CALL return PC (all 32 bits).
- `mem_addr`  out  32  to data memory `address`.
- `mem_wdata`  out  16  to data memory `writeData`.
- `mem_read`, `mem_write`, `mem_cs`  out  1 each  data memory strobes.
- `mem_push`  out  1  toggles on every write cycle.
- `mem_rdata`  in  16  from data memory `readData`. Combinational, valid in the same cycle.
- `out_valid`  out  1  one-cycle pulse; result is present.
- `out_data`  out  32  load/pop data zero-extended, or the popped 32-bit PC.
- `out_err`  out  1  stack underflow on this result.
- `sp`  out  32  current stack pointer.

## Operation
- FSM states: IDLE, WORD0, WORD1. An accepted request is latched into op/addr/data registers.
  - Accepted NOP goes to IDLE and produces no `out_valid`.
  - All other accepted ops go to WORD0.
- WORD0, by operation:
  - LOAD: read `in_addr`.
  - STORE: write `in_wdata[15:0]` at `in_addr`.
  - PUSH: write at SP, then SP−1.
  - POP: read at SP+1, then SP+1.
  - CALL: write `wdata[31:16]` at SP, go to WORD1.
  - RET: read SP+1 (low half), go to WORD1.
- WORD1, by operation:
  - CALL: write `wdata[15:0]` at SP−1, then SP−2.
  - RET: read SP+2 (high half), then SP+2.
- Push order is high word at the higher address. RET reassembles `{word@SP+2, word@SP+1}`.
- `mem_cs` is high in every access cycle. Read and write are mutually exclusive and both are 0 in IDLE. `mem_addr` and `mem_wdata` hold their last value in IDLE.
- `mem_push` toggles in every write cycle, so back-to-back writes re-trigger the event-driven memory write.
- Underflow: a POP with SP == `SP_RESET`, or a RET with SP ≥ `SP_RESET`−1.
  - No read strobe is issued and SP is unchanged.
  - The op still completes in WORD0 with `out_valid=1`, `out_err=1`, `out_data=0`.
  - A RET that underflows does not enter WORD1.
- PUSH/CALL have no overflow check; SP wraps modulo 2^32.
- `in_ready` = (state==IDLE) or (last access cycle of the current op). This gives full throughput for single-word ops and one bubble for CALL/RET.

## Timing
- Reset values:
  - state IDLE, SP = `SP_RESET`.
  - `in_ready`=1; `out_valid`, `out_err`, `mem_read`, `mem_write`, `mem_cs`, `mem_push` = 0.
  - `out_data`, `mem_addr`, `mem_wdata` = 0.
- Accept at edge N gives the access in cycle N..N+1.
  - `out_valid`/`out_data` are registered at the end of the last access cycle and visible one cycle later: latency 2 for single-word ops, 3 for CALL/RET.
- `out_valid` is produced for STORE/PUSH/CALL too, with `out_data`=0, to retire the op.
- SP updates at the end of the op's last access cycle. A following op accepted in that cycle sees the new SP.
- Reset mid-operation: abort immediately to reset values. A half-done CALL leaves one written word in memory and is not retired.

## Structure
- Shared package `mem_pkg`: op encodings, state encodings, `SP_RESET`, and the memory depth 2^11.
- One natural sub-module: `stack_ptr`, which holds the SP register, the ±1/±2 adder, and underflow detection. The FSM and datapath stay in `mem_stage_ctrl`.

## Test plan
- After reset: PUSH 0x1234, then POP → write at 0x7FF, SP 0x7FE; POP reads 0x7FF, `out_data`=0x0000_1234, SP back to 0x7FF, `out_err`=0.
- STORE 0xBEEF at address 0x10, then LOAD 0x10 back-to-back with `in_valid` held → `in_ready` stays 1, LOAD `out_data`=0x0000_BEEF two cycles after its accept.
- CALL PC=0xA5A5_5A5A, then RET → 0x7FF=0xA5A5, 0x7FE=0x5A5A, SP 0x7FD; RET returns 0xA5A5_5A5A with SP 0x7FF; `in_ready` low for one cycle each.
- POP at SP=0x7FF → `out_err`=1, `out_data`=0, `mem_read` never asserted, SP stays 0x7FF.
- Two consecutive PUSHes → `mem_push` toggles twice and both words are written (0x7FF, 0x7FE).
- Assert `rst` during WORD1 of a CALL → outputs return to reset values asynchronously, SP=0x7FF, no `out_valid`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and constants for the memory-stage controller.
package mem_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_STORE = 3'd2,
      OP_PUSH  = 3'd3,
      OP_POP   = 3'd4,
      OP_CALL  = 3'd5,
      OP_RET   = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WORD0 = 2'd1,
      S_WORD1 = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      SP_HOLD = 3'd0,
      SP_INC1 = 3'd1,
      SP_INC2 = 3'd2,
      SP_DEC1 = 3'd3,
      SP_DEC2 = 3'd4
   } sp_op_e;

   localparam int          MEM_AW       = 11;
   localparam int          MEM_DEPTH    = 1 << MEM_AW;
   localparam logic [31:0] SP_RESET_DEF = 32'h0000_07FF;

endpackage

// File: rtl/mem_stage_ctrl_stack_ptr.sv
// Stack pointer register with its +/-1, +/-2 neighbours and underflow flags.
module stack_ptr
   import mem_pkg::*;
#(
   parameter logic [31:0] SP_RESET = SP_RESET_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  sp_op_e      sp_op,
   output logic [31:0] sp,
   output logic [31:0] sp_inc1,
   output logic [31:0] sp_inc2,
   output logic [31:0] sp_dec1,
   output logic        pop_uflow,
   output logic        ret_uflow
);

   assign sp_inc1   = sp + 32'd1;
   assign sp_inc2   = sp + 32'd2;
   assign sp_dec1   = sp - 32'd1;
   // RET needs two words on the stack, so SP_RESET-1 already underflows
   assign pop_uflow = (sp == SP_RESET);
   assign ret_uflow = (sp >= (SP_RESET - 32'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp <= SP_RESET;
      end else begin
         case (sp_op)
            SP_INC1: sp <= sp_inc1;
            SP_INC2: sp <= sp_inc2;
            SP_DEC1: sp <= sp_dec1;
            SP_DEC2: sp <= sp - 32'd2;
            default: sp <= sp;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences loads/stores and stack ops (CALL/RET over two
// access cycles) onto a 16-bit data memory; results are registered one cycle later.
module mem_stage_ctrl
   import mem_pkg::*;
#(
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] SP_RESET = SP_RESET_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [31:0]       in_addr,
   input  logic [31:0]       in_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_cs,
   output logic              mem_push,
   input  logic [15:0]       mem_rdata,
   output logic              out_valid,
   output logic [31:0]       out_data,
   output logic              out_err,
   output logic [31:0]       sp
);

   state_e      state, state_n;
   op_e         op_q;
   logic [31:0] addr_q, wdata_q;
   logic [15:0] lo_q;
   logic [31:0] addr_c, addr_hold;
   logic [15:0] wdata_hold;
   logic        push_q;
   sp_op_e      sp_op;
   logic [31:0] sp_inc1, sp_inc2, sp_dec1;
   logic        pop_uflow, ret_uflow;
   logic        last, res_err;
   logic [31:0] res_dat;
   logic        accept, in_is_nop;

   stack_ptr #(.SP_RESET(SP_RESET)) u_sp (
      .clk       (clk),
      .rst       (rst),
      .sp_op     (sp_op),
      .sp        (sp),
      .sp_inc1   (sp_inc1),
      .sp_inc2   (sp_inc2),
      .sp_dec1   (sp_dec1),
      .pop_uflow (pop_uflow),
      .ret_uflow (ret_uflow)
   );

   assign mem_addr  = ADDR_W'(addr_c);
   // Toggle edge on every write cycle re-triggers the event-driven memory write
   assign mem_push  = push_q ^ mem_write;
   assign in_is_nop = (in_op == OP_NOP) || (in_op == OP_RSVD);
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_n   = state;
      sp_op     = SP_HOLD;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_cs    = 1'b0;
      addr_c    = addr_hold;
      mem_wdata = wdata_hold;
      last      = 1'b0;
      res_err   = 1'b0;
      res_dat   = 32'd0;
      case (state)
         S_WORD0: begin
            mem_cs = 1'b1;
            case (op_q)
               OP_LOAD: begin
                  mem_read = 1'b1;
                  addr_c   = addr_q;
                  res_dat  = {16'h0, mem_rdata};
                  last     = 1'b1;
               end
               OP_STORE: begin
                  mem_write = 1'b1;
                  addr_c    = addr_q;
                  mem_wdata = wdata_q[15:0];
                  last      = 1'b1;
               end
               OP_PUSH: begin
                  mem_write = 1'b1;
                  addr_c    = sp;
                  mem_wdata = wdata_q[15:0];
                  sp_op     = SP_DEC1;
                  last      = 1'b1;
               end
               OP_POP: begin
                  last = 1'b1;
                  if (pop_uflow) begin
                     res_err = 1'b1;
                  end else begin
                     mem_read = 1'b1;
                     addr_c   = sp_inc1;
                     res_dat  = {16'h0, mem_rdata};
                     sp_op    = SP_INC1;
                  end
               end
               OP_CALL: begin
                  mem_write = 1'b1;
                  addr_c    = sp;
                  mem_wdata = wdata_q[31:16];
                  state_n   = S_WORD1;
               end
               OP_RET: begin
                  if (ret_uflow) begin
                     res_err = 1'b1;
                     last    = 1'b1;
                  end else begin
                     mem_read = 1'b1;
                     addr_c   = sp_inc1;
                     state_n  = S_WORD1;
                  end
               end
               default: last = 1'b1;
            endcase
         end
         S_WORD1: begin
            mem_cs = 1'b1;
            last   = 1'b1;
            if (op_q == OP_CALL) begin
               mem_write = 1'b1;
               addr_c    = sp_dec1;
               mem_wdata = wdata_q[15:0];
               sp_op     = SP_DEC2;
            end else begin
               mem_read = 1'b1;
               addr_c   = sp_inc2;
               res_dat  = {mem_rdata, lo_q};
               sp_op    = SP_INC2;
            end
         end
         default: ;
      endcase
      in_ready = (state == S_IDLE) || last;
      if (last) state_n = S_IDLE;
      if (in_valid && in_ready) state_n = in_is_nop ? S_IDLE : S_WORD0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         op_q       <= OP_NOP;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         lo_q       <= 16'd0;
         addr_hold  <= 32'd0;
         wdata_hold <= 16'd0;
         push_q     <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= 32'd0;
         out_err    <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_q    <= op_e'(in_op);
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
         end
         if (state == S_WORD0 && op_q == OP_RET) lo_q <= mem_rdata;
         addr_hold  <= addr_c;
         wdata_hold <= mem_wdata;
         push_q     <= mem_push;
         out_valid  <= last;
         out_data   <= res_dat;
         out_err    <= res_err;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed table, hand-written corner sequences, and a
// randomized run checked against a transaction-level stack/memory model.
module tb_mem_stage_ctrl;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'd0;
   logic [31:0] in_addr = 32'd0;
   logic [31:0] in_wdata = 32'd0;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_read, mem_write, mem_cs, mem_push;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_err;
   logic [31:0] sp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.ADDR_W(32), .SP_RESET(32'h0000_07FF)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_addr(in_addr), .in_wdata(in_wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_cs(mem_cs), .mem_push(mem_push),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
      .sp(sp)
   );

   logic [15:0] tbmem [0:MEM_DEPTH-1];
   always @(posedge clk) if (mem_write && mem_cs) tbmem[mem_addr[10:0]] <= mem_wdata;
   assign mem_rdata = tbmem[mem_addr[10:0]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Issue one op from idle and wait for its retirement.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] d, output logic e, output int acc,
                        output logic rdy_after, output logic rd_seen);
      int t;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd;
      t = 0;
      while (!in_ready && t < 10) begin @(negedge clk); t++; end
      if (t == 10) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      rdy_after = in_ready;
      rd_seen   = 1'b0;
      acc       = 0;
      while (!out_valid && acc < 10) begin
         if (mem_read) rd_seen = 1'b1;
         @(negedge clk);
         acc++;
      end
      d = out_data;
      e = out_err;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_d;
      logic        exp_e;
      int          exp_acc;
      logic [31:0] exp_sp;
   } vec_t;

   function automatic vec_t mk(input op_e op, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] ed, input logic ee, input int ea,
                               input logic [31:0] esp);
      vec_t v;
      v.op = op; v.addr = a; v.wd = wd; v.exp_d = ed; v.exp_e = ee; v.exp_acc = ea; v.exp_sp = esp;
      return v;
   endfunction

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        err;
      logic [31:0] sp;
   } res_t;

   vec_t        tbl [16];
   res_t        q [$];
   logic [15:0] mmem [0:MEM_DEPTH-1];

   initial begin
      logic [31:0] d, sp_before, tmp, msp, sp_vis;
      logic        e, rdy, rds, lastp, vflag;
      int          acc, tog, rem, edge_n, n, exp_rd, exp_wr, rd_cnt, wr_cnt, bad;
      logic [15:0] t7fc;
      res_t        r;

      tbl[0]  = mk(OP_PUSH,  32'h0,   32'h0000_1234, 32'h0,         1'b0, 1, 32'h7FE);
      tbl[1]  = mk(OP_POP,   32'h0,   32'h0,         32'h0000_1234, 1'b0, 1, 32'h7FF);
      tbl[2]  = mk(OP_POP,   32'h0,   32'h0,         32'h0,         1'b1, 1, 32'h7FF);
      tbl[3]  = mk(OP_STORE, 32'h10,  32'h0000_BEEF, 32'h0,         1'b0, 1, 32'h7FF);
      tbl[4]  = mk(OP_LOAD,  32'h10,  32'h0,         32'h0000_BEEF, 1'b0, 1, 32'h7FF);
      tbl[5]  = mk(OP_CALL,  32'h0,   32'hA5A5_5A5A, 32'h0,         1'b0, 2, 32'h7FD);
      tbl[6]  = mk(OP_RET,   32'h0,   32'h0,         32'hA5A5_5A5A, 1'b0, 2, 32'h7FF);
      tbl[7]  = mk(OP_RET,   32'h0,   32'h0,         32'h0,         1'b1, 1, 32'h7FF);
      tbl[8]  = mk(OP_PUSH,  32'h0,   32'h5555_ABCD, 32'h0,         1'b0, 1, 32'h7FE);
      tbl[9]  = mk(OP_LOAD,  32'h7FF, 32'h0,         32'h0000_ABCD, 1'b0, 1, 32'h7FE);
      tbl[10] = mk(OP_PUSH,  32'h0,   32'h0000_7777, 32'h0,         1'b0, 1, 32'h7FD);
      tbl[11] = mk(OP_RET,   32'h0,   32'h0,         32'hABCD_7777, 1'b0, 2, 32'h7FF);
      tbl[12] = mk(OP_RET,   32'h0,   32'h0,         32'h0,         1'b1, 1, 32'h7FF);
      tbl[13] = mk(OP_PUSH,  32'h0,   32'h0000_0001, 32'h0,         1'b0, 1, 32'h7FE);
      tbl[14] = mk(OP_RET,   32'h0,   32'h0,         32'h0,         1'b1, 1, 32'h7FE);
      tbl[15] = mk(OP_POP,   32'h0,   32'h0,         32'h0000_0001, 1'b0, 1, 32'h7FF);

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_strobes", {28'd0, mem_read, mem_write, mem_cs, mem_push}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_sp", sp, 32'h7FF);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         sp_before = sp;
         do_op(tbl[i].op, tbl[i].addr, tbl[i].wd, d, e, acc, rdy, rds);
         chk($sformatf("tbl%0d_data", i), d, tbl[i].exp_d);
         chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_e));
         chk($sformatf("tbl%0d_latency", i), 32'(acc), 32'(tbl[i].exp_acc));
         chk($sformatf("tbl%0d_sp", i), sp, tbl[i].exp_sp);
         chk($sformatf("tbl%0d_ready_after_accept", i), 32'(rdy), 32'(tbl[i].exp_acc == 1));
         if (tbl[i].exp_e) chk($sformatf("tbl%0d_no_read_on_uflow", i), 32'(rds), 32'd0);
         if (tbl[i].op == OP_CALL) begin
            tmp = sp_before - 32'd1;
            chk($sformatf("tbl%0d_call_hi", i), 32'(tbmem[sp_before[10:0]]), 32'(tbl[i].wd[31:16]));
            chk($sformatf("tbl%0d_call_lo", i), 32'(tbmem[tmp[10:0]]), 32'(tbl[i].wd[15:0]));
         end
      end

      // STORE then LOAD with in_valid held
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_STORE; in_addr = 32'h20; in_wdata = 32'h0000_1357;
      chk("b2b_ready0", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_op = OP_LOAD;
      chk("b2b_ready1", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_store_retire", {out_valid, out_data[30:0]}, 32'h8000_0000);
      @(negedge clk);
      chk("b2b_load_valid", 32'(out_valid), 32'd1);
      chk("b2b_load_data", out_data, 32'h0000_1357);

      // two PUSHes back to back
      @(negedge clk);
      lastp = mem_push; tog = 0;
      in_valid = 1'b1; in_op = OP_PUSH; in_wdata = 32'h0000_00AA;
      @(negedge clk);
      if (mem_push !== lastp) tog++;
      lastp = mem_push; in_wdata = 32'h0000_00BB;
      @(negedge clk);
      if (mem_push !== lastp) tog++;
      lastp = mem_push; in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (mem_push !== lastp) tog++;
         lastp = mem_push;
      end
      chk("push2_toggles", 32'(tog), 32'd2);
      chk("push2_word0", 32'(tbmem[11'h7FF]), 32'h00AA);
      chk("push2_word1", 32'(tbmem[11'h7FE]), 32'h00BB);
      chk("push2_sp", sp, 32'h7FD);

      // reset while a CALL sits in its second word
      t7fc = tbmem[11'h7FC];
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_CALL; in_wdata = 32'h1357_2468;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_strobes", {28'd0, mem_read, mem_write, mem_cs, mem_push}, 32'd0);
      chk("arst_mem_addr", mem_addr, 32'd0);
      chk("arst_sp", sp, 32'h7FF);
      @(negedge clk);
      rst = 1'b0;
      vflag = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) vflag = 1'b1;
      end
      chk("arst_no_retire", 32'(vflag), 32'd0);
      chk("arst_hi_written", 32'(tbmem[11'h7FD]), 32'h1357);
      chk("arst_lo_not_written", 32'(tbmem[11'h7FC]), 32'(t7fc));

      // randomized run against a transaction-level model
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mmem[i] = tbmem[i];
      msp = 32'h7FF; sp_vis = 32'h7FF; rem = 0; edge_n = 0;
      exp_rd = 0; exp_wr = 0; rd_cnt = 0; wr_cnt = 0; bad = 0; tog = 0;
      lastp = mem_push;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (q.size() > 0 && q[0].due == edge_n) begin
            r = q.pop_front();
            chk("rnd_out_valid", 32'(out_valid), 32'd1);
            chk("rnd_out_data", out_data, r.d);
            chk("rnd_out_err", 32'(out_err), 32'(r.err));
            sp_vis = r.sp;
         end else begin
            chk("rnd_out_valid", 32'(out_valid), 32'd0);
         end
         chk("rnd_sp", sp, sp_vis);
         chk("rnd_in_ready", 32'(in_ready), 32'(rem <= 1));
         if (mem_read) rd_cnt++;
         if (mem_write) wr_cnt++;
         if (mem_push !== lastp) tog++;
         lastp = mem_push;
         if ((mem_read && mem_write) || ((mem_read || mem_write) && !mem_cs)) bad++;

         in_valid = (cyc < 2950) && ($urandom_range(0, 3) != 0);
         in_op    = 3'($urandom_range(0, 7));
         in_addr  = $urandom;
         in_wdata = $urandom;
         @(posedge clk);
         edge_n++;
         if (in_valid && rem <= 1) begin
            r.d = 32'd0; r.err = 1'b0; n = 1;
            case (in_op)
               OP_LOAD: begin r.d = {16'h0, mmem[in_addr[10:0]]}; exp_rd++; end
               OP_STORE: begin mmem[in_addr[10:0]] = in_wdata[15:0]; exp_wr++; end
               OP_PUSH: begin mmem[msp[10:0]] = in_wdata[15:0]; msp = msp - 1; exp_wr++; end
               OP_POP: begin
                  if (msp == 32'h7FF) r.err = 1'b1;
                  else begin msp = msp + 1; r.d = {16'h0, mmem[msp[10:0]]}; exp_rd++; end
               end
               OP_CALL: begin
                  mmem[msp[10:0]] = in_wdata[31:16];
                  tmp = msp - 1;
                  mmem[tmp[10:0]] = in_wdata[15:0];
                  msp = msp - 2; n = 2; exp_wr += 2;
               end
               OP_RET: begin
                  if (msp >= 32'h7FE) r.err = 1'b1;
                  else begin
                     tmp = msp + 1;
                     r.d[15:0] = mmem[tmp[10:0]];
                     tmp = msp + 2;
                     r.d[31:16] = mmem[tmp[10:0]];
                     msp = msp + 2; n = 2; exp_rd += 2;
                  end
               end
               default: n = 0;
            endcase
            rem = n;
            if (n > 0) begin
               r.due = edge_n + n;
               r.sp  = msp;
               q.push_back(r);
            end
         end else if (rem > 0) begin
            rem--;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("rnd_drained", 32'(q.size()), 32'd0);
      chk("rnd_read_cycles", 32'(rd_cnt), 32'(exp_rd));
      chk("rnd_write_cycles", 32'(wr_cnt), 32'(exp_wr));
      chk("rnd_push_toggles", 32'(tog), 32'(exp_wr));
      chk("rnd_strobe_rules", 32'(bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
